// File: rtl/qr_seg_sequencer.sv
// qr_seg_sequencer: accepts one packed divider result {quotient, remainder}
// and plays it out on a single 7-segment digit as quotient, blank,
// remainder with decimal point, blank. The code 0xFF shows an 'E' glyph.
module qr_seg_sequencer #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       res_valid,
    input  logic [7:0] res_data,
    output logic       res_ready,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic       busy,
    output logic       err_out
);

    localparam int unsigned MAX_DUR = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    GLYPH_E  = 7'h79;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_Q,
        GAP_Q,
        SHOW_R,
        GAP_R,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    rem_q, rem_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          err_q, err_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next state, dwell counter and the registered display values for the
    // state being entered, so outputs are valid in its first cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (res_valid) begin
                    // Only the remainder is needed later; the quotient is
                    // decoded straight into the display register here.
                    rem_d = res_data[3:0];
                    cnt_d = DWELL_LD;
                    if (res_data == 8'hFF) begin
                        state_d = ERR;
                        seg_d   = GLYPH_E;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SHOW_Q;
                        seg_d   = hex7(res_data[7:4]);
                    end
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    seg_d = '0;
                    dp_d  = 1'b0;
                    err_d = 1'b0;
                    case (state_q)
                        SHOW_Q: begin
                            state_d = GAP_Q;
                            cnt_d   = BLANK_LD;
                        end
                        GAP_Q: begin
                            state_d = SHOW_R;
                            cnt_d   = DWELL_LD;
                            seg_d   = hex7(rem_q);
                            dp_d    = 1'b1;
                        end
                        SHOW_R: begin
                            state_d = GAP_R;
                            cnt_d   = BLANK_LD;
                        end
                        default: begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    // State and output registers; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            err_q   <= err_d;
        end
    end

    assign res_ready = (state_q == IDLE);
    assign busy      = ~res_ready;
    assign seg_out   = seg_q;
    assign dp_out    = dp_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_qr_seg_sequencer.sv
// Bench for qr_seg_sequencer: expected display traces are built per result
// byte from the phase durations and a hex glyph table.
module tb_qr_seg_sequencer;

    localparam int DW = 4;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;
    logic [6:0] seg_out;
    logic       dp_out;
    logic       busy;
    logic       err_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    qr_seg_sequencer #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .busy      (busy),
        .err_out   (err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected per-enabled-cycle display after the transfer edge.
    task automatic build_expected(input logic [7:0] d);
        exp_t e;
        exp_q.delete();
        if (d == 8'hFF) begin
            e.seg = 7'h79; e.dp = 1'b0; e.err = 1'b1;
            repeat (DW) exp_q.push_back(e);
        end else begin
            e.seg = HEX[d[7:4]]; e.dp = 1'b0; e.err = 1'b0;
            repeat (DW) exp_q.push_back(e);
            e = '0;
            repeat (BL) exp_q.push_back(e);
            e.seg = HEX[d[3:0]]; e.dp = 1'b1; e.err = 1'b0;
            repeat (DW) exp_q.push_back(e);
            e = '0;
            repeat (BL) exp_q.push_back(e);
        end
    endtask

    // Called at #1 after a posedge with the block idle.
    task automatic do_transfer(input logic [7:0] d);
        int waited = 0;
        while (res_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (res_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL transfer_wait: res_ready=%b required 1 within 50 cycles", res_ready);
        end
        res_valid = 1'b1;
        res_data  = d;
        @(posedge clk); #1;
        res_valid = 1'b0;
        res_data  = 8'($urandom);
    endtask

    // Plays the sequence for d starting at the first cycle after transfer.
    task automatic play(input logic [7:0] d, input string name, input int stall_at,
                        input int stall_len, input bit rnd_stall, input bit hold,
                        input logic [7:0] hold_d);
        int k;
        build_expected(d);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (hold) begin
                res_valid = 1'b1;
                res_data  = (i == exp_q.size() / 2) ? 8'h55 : hold_d;
            end
            n_checks++;
            if ({seg_out, dp_out, err_out, res_ready, busy} !==
                {exp_q[i].seg, exp_q[i].dp, exp_q[i].err, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL %s[%0d]: seg=%h dp=%b err=%b rdy=%b busy=%b required seg=%h dp=%b err=%b rdy=0 busy=1",
                         name, i, seg_out, dp_out, err_out, res_ready, busy,
                         exp_q[i].seg, exp_q[i].dp, exp_q[i].err);
            end
            k = (i == stall_at) ? stall_len :
                ((rnd_stall && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            for (int s = 0; s < k; s++) begin
                ena = 1'b0;
                @(posedge clk); #1;
                n_checks++;
                if ({seg_out, dp_out, err_out, res_ready} !==
                    {exp_q[i].seg, exp_q[i].dp, exp_q[i].err, 1'b0}) begin
                    n_fail++;
                    $display("FAIL %s_frozen[%0d.%0d]: seg=%h dp=%b err=%b rdy=%b required seg=%h dp=%b err=%b rdy=0",
                             name, i, s, seg_out, dp_out, err_out, res_ready,
                             exp_q[i].seg, exp_q[i].dp, exp_q[i].err);
                end
            end
            ena = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if ({seg_out, dp_out, err_out, res_ready, busy} !== {7'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_end: seg=%h dp=%b err=%b rdy=%b busy=%b required seg=00 dp=0 err=0 rdy=1 busy=0",
                     name, seg_out, dp_out, err_out, res_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; res_valid = 1'b0; res_data = 8'h00;
        #2;
        n_checks++;
        if ({seg_out, dp_out, err_out, res_ready, busy} !== {7'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: seg=%h dp=%b err=%b rdy=%b busy=%b required 00/0/0/1/0",
                     seg_out, dp_out, err_out, res_ready, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (res_ready !== 1'b1 || seg_out !== 7'h00) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b seg=%h required rdy=1 seg=00", res_ready, seg_out);
        end
    endtask

    task automatic test_basic();
        do_transfer(8'h32);
        play(8'h32, "basic_32", -1, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_error();
        do_transfer(8'hFF);
        play(8'hFF, "error_ff", -1, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        do_transfer(8'h32);
        play(8'h32, "hold_32", -1, 0, 1'b0, 1'b1, 8'h21);
        do_transfer(8'h21);
        play(8'h21, "hold_21", -1, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_enable_freeze();
        do_transfer(8'h32);
        play(8'h32, "ena_freeze", DW + BL + 1, 3, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_async_reset();
        do_transfer(8'h32);
        repeat (DW + 1) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({seg_out, dp_out, err_out, res_ready, busy} !== {7'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: seg=%h dp=%b err=%b rdy=%b busy=%b required 00/0/0/1/0",
                     seg_out, dp_out, err_out, res_ready, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_transfer(8'h10);
        play(8'h10, "after_reset_10", -1, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_hex_edges();
        do_transfer(8'hA0);
        play(8'hA0, "hex_a0", -1, 0, 1'b0, 1'b0, 8'h00);
        do_transfer(8'hFE);
        play(8'hFE, "hex_fe", -1, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 5) == 0) d = 8'hFF;
            else d = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 14))};
            do_transfer(d);
            play(d, "random", -1, 0, 1'b1, 1'b0, 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_back_to_back();
        test_enable_freeze();
        test_async_reset();
        test_hex_edges();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
